audio_soft_mute: RTL and testbench
==================================

Name: audio_soft_mute

Overview:
- Sits between the audio_eq output (data_out / data_valid_out) and the es8388_ctrl dac_data input.
- Replaces the hard mute mux with a debounced mute switch and a linear per-frame gain ramp, so muting and unmuting produce no audible pops.
- Runs in the aud_bclk domain alongside audio_eq.
- Each frame is stereo, 32 bits: {L[31:16], R[15:0]}, both channels 16-bit two's complement.

Parameters:
- GAIN_STEP, 1: gain increment/decrement per valid frame, range 1..256. With the default, a full ramp takes 256 frames (about 5.3 ms at 48 kHz).
- DEBOUNCE_FRAMES, 480: number of consecutive valid frames the synchronised switch must hold a new level before it is accepted (10 ms at 48 kHz). Counter width is clog2(DEBOUNCE_FRAMES+1).

Ports:
- clk, input, 1: audio bit clock (aud_bclk).
- rst_n, input, 1: reset, synchronous, active-low.
- mute_sw_n, input, 1: raw asynchronous switch; 1 = play, 0 = mute.
- data_in, input, 32: stereo frame from audio_eq.
- data_valid, input, 1: one-cycle strobe qualifying data_in.
- data_out, output, 32: gain-scaled stereo frame to es8388_ctrl.
- data_valid_out, output, 1: one-cycle strobe qualifying data_out.
- muted, output, 1: 1 while state is MUTED.
- ramping, output, 1: 1 while state is RAMP_UP or RAMP_DOWN.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-low.

Reset (rst_n=0 at a clk edge):
- data_out=0, data_valid_out=0, pipeline registers=0.
- gain=0, state=MUTED, muted=1, ramping=0.
- Synchroniser flops=0, debounced play flag=0, debounce counter=0.
- A reset asserted mid-ramp aborts the ramp immediately. No partially scaled frame is emitted after reset.

Switch conditioning:
- mute_sw_n passes through a 2-FF synchroniser to give sw_s.
- Debounce: on each data_valid, if sw_s != play_flag, the counter increments; otherwise it clears.
- When the counter reaches DEBOUNCE_FRAMES-1 with a mismatch still present, play_flag <= sw_s and the counter clears.
- Glitches shorter than DEBOUNCE_FRAMES frames are ignored.

State machine (advances only on data_valid):
- MUTED: gain=0. If play_flag=1, go to RAMP_UP.
- RAMP_UP: gain <= min(gain+GAIN_STEP, 256). When the new gain is 256, go to UNMUTED. If play_flag=0, go to RAMP_DOWN with no gain jump.
- UNMUTED: gain=256. If play_flag=0, go to RAMP_DOWN.
- RAMP_DOWN: gain <= max(gain-GAIN_STEP, 0). When the new gain is 0, go to MUTED. If play_flag=1, go to RAMP_UP with no gain jump.
- A direction reversal mid-ramp starts from the current gain. Gain is 9-bit unsigned, range 0..256, and never wraps.
- If play_flag and a ramp endpoint change on the same frame, the play_flag test wins and the endpoint state is skipped.

Datapath (2-stage pipeline, latency 2 clk):
- Stage 1, on data_valid: register L, R, and the current (pre-update) gain.
- Stage 2, per channel: product = signed16 × {1'b0, gain} (25-bit signed); out = product[23:8] (arithmetic shift right by 8).
- At gain=256, out == in exactly. At gain=0, out=0.
- No saturation is needed because |out| ≤ 32768 and -32768 is representable.
- data_valid_out = data_valid delayed by 2 clk. data_out holds its value between strobes.
- data_valid on consecutive clk cycles must be accepted without loss.

Test Plan:
1. Reset behaviour: release rst_n with mute_sw_n=1, then drive 480 frames of data_in=32'h4000_C000 -> data_out=0 and muted=1 for those frames. RAMP_UP begins on the 481st strobe. After 256 further frames: gain=256, data_out=32'h4000_C000, state UNMUTED, ramping=0.
2. Pipeline latency: in UNMUTED, drive data_valid on 3 consecutive clk cycles with frames A, B, C -> data_valid_out high on cycles +2, +3, +4 carrying A, B, C unchanged.
3. Arithmetic: at gain=128, input {16'h8000, 16'h7FFF} -> output {16'hC000, 16'h3FFF}. At gain=1, input 16'hFFFF -> 16'hFFFF (floor of -1/256).
4. Mid-ramp reversal: in UNMUTED, set mute_sw_n=0 for 480 frames, then let gain ramp to 100, then set mute_sw_n=1 for 480 frames -> gain continues ramping down to 100-480 clamped at 0 (MUTED), then ramps up from 0. There must be no step discontinuity larger than GAIN_STEP.
5. Glitch rejection: in UNMUTED, pulse mute_sw_n=0 for 479 frames, then 1 -> gain stays at 256, ramping stays 0, and the counter returns to 0.
6. Reset mid-ramp: assert rst_n=0 for 1 clk at gain=57 in RAMP_DOWN -> on the next edge gain=0, muted=1, data_valid_out=0. The next two data_valid strobes produce data_out=0.

Source files
------------

// File: rtl/audio_soft_mute.sv
// Pop-free mute stage between the EQ and the DAC serialiser: debounced mute switch plus a
// linear per-frame gain ramp applied to both 16-bit channels with a 2-cycle pipeline.
module audio_soft_mute #(
  parameter int unsigned GAIN_STEP       = 1,
  parameter int unsigned DEBOUNCE_FRAMES = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mute_sw_n,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic [31:0] data_out,
  output logic        data_valid_out,
  output logic        muted,
  output logic        ramping
);

  localparam int unsigned      CntW    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_FRAMES - 1);
  localparam logic [9:0]       Step    = 10'(GAIN_STEP);
  localparam logic [8:0]       GainMax = 9'd256;

  typedef enum logic [1:0] {StMuted, StRampUp, StUnmuted, StRampDown} state_e;

  logic            r_sync1, r_sync2;
  logic            r_play;
  logic [CntW-1:0] r_cnt;
  state_e          r_state;
  logic [8:0]      r_gain;

  logic [15:0]     r_l, r_r;
  logic [8:0]      r_g;
  logic            r_v1;

  logic [9:0]      w_up_sum, w_dn_diff;
  logic [8:0]      w_gain_up, w_gain_dn;
  logic [23:0]     w_prod_l, w_prod_r;
  logic [15:0]     w_out_l, w_out_r;

  // Switch synchroniser and frame-counted debounce
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_play  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= mute_sw_n;
      r_sync2 <= r_sync1;
      if (data_valid) begin
        if (r_sync2 != r_play) begin
          if (r_cnt == CntLast) begin
            r_play <= r_sync2;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign w_up_sum  = {1'b0, r_gain} + Step;
  assign w_dn_diff = {1'b0, r_gain} - Step;
  assign w_gain_up = (w_up_sum >= 10'd256) ? GainMax : w_up_sum[8:0];
  assign w_gain_dn = ({1'b0, r_gain} <= Step) ? 9'd0 : w_dn_diff[8:0];

  // A play_flag change always wins over reaching a ramp endpoint on the same frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StMuted;
      r_gain  <= '0;
    end else if (data_valid) begin
      case (r_state)
        StMuted: begin
          r_gain <= '0;
          if (r_play) r_state <= StRampUp;
        end
        StRampUp: begin
          if (!r_play) begin
            r_state <= StRampDown;
          end else begin
            r_gain <= w_gain_up;
            if (w_gain_up == GainMax) r_state <= StUnmuted;
          end
        end
        StUnmuted: begin
          r_gain <= GainMax;
          if (!r_play) r_state <= StRampDown;
        end
        StRampDown: begin
          if (r_play) begin
            r_state <= StRampUp;
          end else begin
            r_gain <= w_gain_dn;
            if (w_gain_dn == 9'd0) r_state <= StMuted;
          end
        end
        default: r_state <= StMuted;
      endcase
    end
  end

  assign muted   = (r_state == StMuted);
  assign ramping = (r_state == StRampUp) || (r_state == StRampDown);

  // Low 24 bits of the signed x unsigned product are exact since |product| <= 2^23
  assign w_prod_l = {{8{r_l[15]}}, r_l} * {15'd0, r_g};
  assign w_prod_r = {{8{r_r[15]}}, r_r} * {15'd0, r_g};
  assign w_out_l  = 16'(w_prod_l >> 8);
  assign w_out_r  = 16'(w_prod_r >> 8);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_l            <= '0;
      r_r            <= '0;
      r_g            <= '0;
      r_v1           <= 1'b0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      r_v1 <= data_valid;
      if (data_valid) begin
        r_l <= data_in[31:16];
        r_r <= data_in[15:0];
        r_g <= r_gain;
      end
      data_valid_out <= r_v1;
      if (r_v1) data_out <= {w_out_l, w_out_r};
    end
  end

endmodule

// File: tb/tb_audio_soft_mute.sv
// Directed bench for audio_soft_mute: reset, debounce, ramps, arithmetic, latency, glitch
// rejection and reset mid-ramp, with hand-derived expectations.
module tb_audio_soft_mute;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mute_sw_n = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic [31:0] data_out;
  logic        data_valid_out;
  logic        muted;
  logic        ramping;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] Tone = 32'h4000_C000;

  audio_soft_mute #(
    .GAIN_STEP      (1),
    .DEBOUNCE_FRAMES(480)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mute_sw_n     (mute_sw_n),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_out      (data_out),
    .data_valid_out(data_valid_out),
    .muted         (muted),
    .ramping       (ramping)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Tone input scaled by gain g: L = 16384*g/256, R = -16384*g/256
  function automatic logic [31:0] tone_at(input int g);
    logic [15:0] l, r;
    l = 16'(64 * g);
    r = 16'(-64 * g);
    return {l, r};
  endfunction

  function automatic int gain_of(input logic [31:0] o);
    logic signed [15:0] l;
    l = o[31:16];
    return int'(l) / 64;
  endfunction

  // Called at a negedge; returns at the negedge after the frame's output strobe
  task automatic frame(input logic [31:0] d, output logic [31:0] o, output logic ov);
    data_in    = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    o  = data_out;
    ov = data_valid_out;
  endtask

  task automatic set_sw(input logic v);
    mute_sw_n = v;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] o;
    logic        ov;
    int          bad, jump, prev, g, d, eg;

    // 1: reset and initial unmute
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_data_out", data_out, 32'd0);
    check_eq("rst_dvo", 32'(data_valid_out), 32'd0);
    check_eq("rst_muted", 32'(muted), 32'd1);
    check_eq("rst_ramping", 32'(ramping), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 480; i++) begin
      frame(Tone, o, ov);
      if (o !== 32'd0 || ov !== 1'b1 || muted !== 1'b1) bad++;
    end
    check_eq("t1_debounce_muted", bad, 0);
    check_eq("t1_still_muted", 32'(muted), 32'd1);
    frame(Tone, o, ov);
    check_eq("t1_481_out", o, 32'd0);
    check_eq("t1_481_ramping", 32'(ramping), 32'd1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      frame(Tone, o, ov);
      if (o !== tone_at(i)) bad++;
    end
    check_eq("t1_ramp_up", bad, 0);
    check_eq("t1_unmuted_ramping", 32'(ramping), 32'd0);
    check_eq("t1_unmuted_muted", 32'(muted), 32'd0);
    frame(Tone, o, ov);
    check_eq("t1_unity", o, Tone);

    // 2: back-to-back strobes
    data_in = 32'h1234_8765;
    data_valid = 1'b1;
    @(negedge clk);
    data_in = 32'h7FFF_8000;
    check_eq("t2_dvo_c1", 32'(data_valid_out), 32'd0);
    @(negedge clk);
    data_in = 32'hDEAD_BEEF;
    check_eq("t2_dvo_c2", 32'(data_valid_out), 32'd1);
    check_eq("t2_out_a", data_out, 32'h1234_8765);
    @(negedge clk);
    data_valid = 1'b0;
    check_eq("t2_dvo_c3", 32'(data_valid_out), 32'd1);
    check_eq("t2_out_b", data_out, 32'h7FFF_8000);
    @(negedge clk);
    check_eq("t2_dvo_c4", 32'(data_valid_out), 32'd1);
    check_eq("t2_out_c", data_out, 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("t2_dvo_c5", 32'(data_valid_out), 32'd0);
    check_eq("t2_hold", data_out, 32'hDEAD_BEEF);

    // 4 (with 3): mute, partial ramp down, reversal, clamp, ramp up
    set_sw(1'b0);
    bad = 0;
    for (int i = 0; i < 480; i++) begin
      frame(Tone, o, ov);
      if (o !== Tone || ramping !== 1'b0) bad++;
    end
    check_eq("t4_debounce_unity", bad, 0);
    frame(Tone, o, ov);
    check_eq("t4_481_out", o, Tone);
    check_eq("t4_481_ramping", 32'(ramping), 32'd1);
    bad = 0;
    jump = 0;
    prev = 256;
    for (int j = 0; j < 156; j++) begin
      if (j == 128) begin
        frame({16'h8000, 16'h7FFF}, o, ov);
        check_eq("t3_gain128", o, 32'hC000_3FFF);
        prev = 128;
      end else begin
        frame(Tone, o, ov);
        if (o !== tone_at(256 - j)) bad++;
        g = gain_of(o);
        d = g - prev;
        if (d > 1 || d < -1) jump++;
        prev = g;
      end
    end
    set_sw(1'b1);
    for (int j = 0; j < 480; j++) begin
      eg = (j < 100) ? 100 - j : 0;
      if (j == 99) begin
        frame(32'hFFFF_FFFF, o, ov);
        check_eq("t3_gain1", o, 32'hFFFF_FFFF);
        prev = 1;
      end else begin
        frame(Tone, o, ov);
        if (o !== tone_at(eg)) bad++;
        g = gain_of(o);
        d = g - prev;
        if (d > 1 || d < -1) jump++;
        prev = g;
      end
    end
    check_eq("t4_clamped_muted", 32'(muted), 32'd1);
    for (int j = 0; j < 10; j++) begin
      eg = (j > 0) ? j - 1 : 0;
      frame(Tone, o, ov);
      if (o !== tone_at(eg)) bad++;
      g = gain_of(o);
      d = g - prev;
      if (d > 1 || d < -1) jump++;
      prev = g;
    end
    check_eq("t4_reup_ramping", 32'(ramping), 32'd1);
    check_eq("t4_exact", bad, 0);
    check_eq("t4_no_step", jump, 0);
    for (int j = 0; j < 247; j++) frame(Tone, o, ov);
    check_eq("t4_reunmuted", 32'(ramping), 32'd0);
    frame(Tone, o, ov);
    check_eq("t4_unity", o, Tone);

    // 5: two 479-frame glitches separated by one settled frame
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      set_sw(1'b0);
      for (int i = 0; i < 479; i++) begin
        frame(Tone, o, ov);
        if (o !== Tone || ramping !== 1'b0) bad++;
      end
      set_sw(1'b1);
      frame(Tone, o, ov);
      if (o !== Tone) bad++;
    end
    check_eq("t5_glitch_ignored", bad, 0);
    check_eq("t5_ramping", 32'(ramping), 32'd0);
    check_eq("t5_muted", 32'(muted), 32'd0);

    // 6: reset with a frame in flight at gain 57 during ramp down
    set_sw(1'b0);
    for (int i = 0; i < 481; i++) frame(Tone, o, ov);
    for (int i = 0; i < 199; i++) frame(Tone, o, ov);
    check_eq("t6_pre_reset", o, tone_at(58));
    check_eq("t6_pre_ramping", 32'(ramping), 32'd1);
    data_in = Tone;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("t6_dvo", 32'(data_valid_out), 32'd0);
    check_eq("t6_data_out", data_out, 32'd0);
    check_eq("t6_muted", 32'(muted), 32'd1);
    check_eq("t6_ramping", 32'(ramping), 32'd0);
    frame(Tone, o, ov);
    check_eq("t6_post1", o, 32'd0);
    check_eq("t6_post1_dvo", 32'(ov), 32'd1);
    frame(Tone, o, ov);
    check_eq("t6_post2", o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
